// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared source ids, entry layout and round-robin helper
package writeback_arbiter_pkg;

  typedef logic [1:0] src_t;

  localparam src_t SRC_ALU = 2'd0;
  localparam src_t SRC_MEM = 2'd1;
  localparam src_t SRC_MUL = 2'd2;
  localparam int   NUM_SRC = 3;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int ENTRY_W    = DEF_REG_W + DEF_DATA_W;

  typedef struct packed {
    logic [DEF_REG_W-1:0]  regdest;
    logic [DEF_DATA_W-1:0] value;
  } wb_entry_t;

  // Search order ALU -> MEM -> MUL -> ALU
  function automatic src_t next_src(input src_t s);
    return (s == SRC_MUL) ? SRC_ALU : src_t'(s + 2'd1);
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - execute-unit results in, register-file write port out
interface writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              alu_writereg;
  logic [REG_W-1:0]  alu_regdest;
  logic [DATA_W-1:0] alu_wbvalue;
  logic              alu_stall;

  logic              mem_wb_writereg;
  logic [REG_W-1:0]  mem_wb_regdest;
  logic [DATA_W-1:0] mem_wb_wbvalue;
  logic              mem_stall;

  logic              mul_writereg;
  logic [REG_W-1:0]  mul_regdest;
  logic [DATA_W-1:0] mul_wbvalue;
  logic              mul_stall;

  logic              wb_writereg;
  logic [REG_W-1:0]  wb_regdest;
  logic [DATA_W-1:0] wb_value;
  logic [1:0]        wb_src;
  logic              overflow;

  modport master (
    output alu_writereg, alu_regdest, alu_wbvalue,
    output mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue,
    output mul_writereg, mul_regdest, mul_wbvalue,
    input  alu_stall, mem_stall, mul_stall,
    input  wb_writereg, wb_regdest, wb_value, wb_src, overflow
  );

  modport slave (
    input  alu_writereg, alu_regdest, alu_wbvalue,
    input  mem_wb_writereg, mem_wb_regdest, mem_wb_wbvalue,
    input  mul_writereg, mul_regdest, mul_wbvalue,
    output alu_stall, mem_stall, mul_stall,
    output wb_writereg, wb_regdest, wb_value, wb_src, overflow
  );
endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// rtl/writeback_arbiter_wb_fifo.sv - small per-source result FIFO, push dropped when full
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - buffers ALU/MEM/MUL results and round-robins them onto one write port
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_W      = DEF_REG_W
) (
  input logic               clock,
  input logic               reset,
  writeback_arbiter_if.slave bus
);

  localparam int EW    = REG_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] pop;
  logic [EW-1:0]      din  [NUM_SRC];
  logic [EW-1:0]      head [NUM_SRC];
  logic [CNT_W-1:0]   count[NUM_SRC];

  src_t last;
  src_t cand1;
  src_t cand2;
  src_t grant;
  logic grant_valid;

  // Writes to r0 are architecturally void and never enter a FIFO
  assign req[SRC_ALU] = bus.alu_writereg    && (bus.alu_regdest    != '0);
  assign req[SRC_MEM] = bus.mem_wb_writereg && (bus.mem_wb_regdest != '0);
  assign req[SRC_MUL] = bus.mul_writereg    && (bus.mul_regdest    != '0);

  assign din[SRC_ALU] = {bus.alu_regdest,    bus.alu_wbvalue};
  assign din[SRC_MEM] = {bus.mem_wb_regdest, bus.mem_wb_wbvalue};
  assign din[SRC_MUL] = {bus.mul_regdest,    bus.mul_wbvalue};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_fifo
    wb_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (req[s]),
      .pop   (pop[s]),
      .din   (din[s]),
      .head  (head[s]),
      .count (count[s]),
      .full  (full[s])
    );
    assign nonempty[s] = (count[s] != '0);
    assign pop[s]      = grant_valid && (grant == src_t'(s));
  end

  assign bus.alu_stall = full[SRC_ALU];
  assign bus.mem_stall = full[SRC_MEM];
  assign bus.mul_stall = full[SRC_MUL];

  always_comb begin
    cand1       = next_src(last);
    cand2       = next_src(cand1);
    grant       = last;
    grant_valid = 1'b1;
    if (nonempty[cand1]) begin
      grant = cand1;
    end else if (nonempty[cand2]) begin
      grant = cand2;
    end else if (nonempty[last]) begin
      grant = last;
    end else begin
      grant_valid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last            <= SRC_MUL;
      bus.wb_writereg <= 1'b0;
      bus.wb_regdest  <= '0;
      bus.wb_value    <= '0;
      bus.wb_src      <= '0;
      bus.overflow    <= 1'b0;
    end else begin
      if (|(req & full)) begin
        bus.overflow <= 1'b1;
      end
      if (grant_valid) begin
        last                            <= grant;
        bus.wb_writereg                 <= 1'b1;
        {bus.wb_regdest, bus.wb_value}  <= head[grant];
        bus.wb_src                      <= grant;
      end else begin
        bus.wb_writereg <= 1'b0;
        bus.wb_regdest  <= '0;
        bus.wb_value    <= '0;
      end
    end
  end

endmodule
